harq_combine_scheduler: RTL

// - Per-slot sequencer for the HARQ combine FSM. Holds a per-user config table (CB count, E01, Ncb).
// - On slot start, walks users 0..NUM_USERS-1 and issues one combine request per code block (CB).
// - Drives user index and sizes, waits for CB-complete, then advances. Sits between slot control and the combine FSM.

---
 rtl/harq_comb_pkg.sv | 23 ++
 rtl/harq_user_cfg_table.sv | 56 +++++
 rtl/harq_combine_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/harq_comb_pkg.sv
// Shared widths, error-bit positions and FSM encoding for the HARQ combine scheduler.
package harq_comb_pkg;

    localparam int USER_W       = 4;
    localparam int E01_W        = 14;
    localparam int NCB_W        = 16;
    localparam int CB_CNT_W_DEF = 8;
    localparam int ERR_W        = 3;

    localparam int ERR_CFG_BUSY     = 0;
    localparam int ERR_SLOT_OVERRUN = 1;
    localparam int ERR_TIMEOUT      = 2;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_SCAN      = 6'b000010,
        ST_ISSUE     = 6'b000100,
        ST_WAIT_COMP = 6'b001000,
        ST_NEXT_CB   = 6'b010000,
        ST_DONE      = 6'b100000
    } sched_state_e;

endpackage

// File: rtl/harq_user_cfg_table.sv
// Per-user configuration register file (CB count, E01, Ncb).
// Writes are blocked while a schedule runs; the read port is combinational.
module harq_user_cfg_table
    import harq_comb_pkg::*;
#(
    parameter int NUM_USERS = 16,
    parameter int CB_CNT_W  = CB_CNT_W_DEF
) (
    input  logic                i_core_clk,
    input  logic                i_rx_rst,
    input  logic                busy,
    input  logic                wr_en,
    input  logic [USER_W-1:0]   wr_user,
    input  logic [CB_CNT_W-1:0] wr_cb_num,
    input  logic [E01_W-1:0]    wr_e01,
    input  logic [NCB_W-1:0]    wr_ncb,
    input  logic [USER_W-1:0]   rd_user,
    output logic [CB_CNT_W-1:0] rd_cb_num,
    output logic [E01_W-1:0]    rd_e01,
    output logic [NCB_W-1:0]    rd_ncb
);

    logic [CB_CNT_W-1:0] cb_num_arr [NUM_USERS];
    logic [E01_W-1:0]    e01_arr    [NUM_USERS];
    logic [NCB_W-1:0]    ncb_arr    [NUM_USERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_USERS; gi++) begin : g_entry
            logic [CB_CNT_W-1:0] cb_num_reg;
            logic [E01_W-1:0]    e01_reg;
            logic [NCB_W-1:0]    ncb_reg;

            always_ff @(posedge i_core_clk) begin
                if (i_rx_rst) begin
                    cb_num_reg <= '0;
                    e01_reg    <= '0;
                    ncb_reg    <= '0;
                end else if (wr_en && !busy && (wr_user == USER_W'(gi))) begin
                    cb_num_reg <= wr_cb_num;
                    e01_reg    <= wr_e01;
                    ncb_reg    <= wr_ncb;
                end
            end

            assign cb_num_arr[gi] = cb_num_reg;
            assign e01_arr[gi]    = e01_reg;
            assign ncb_arr[gi]    = ncb_reg;
        end
    endgenerate

    assign rd_cb_num = cb_num_arr[rd_user];
    assign rd_e01    = e01_arr[rd_user];
    assign rd_ncb    = ncb_arr[rd_user];

endmodule

// File: rtl/harq_combine_scheduler.sv
// Per-slot HARQ combine sequencer: walks the user table and issues one combine
// request per code block, waiting for each completion before advancing.
module harq_combine_scheduler
    import harq_comb_pkg::*;
#(
    parameter int NUM_USERS   = 16,
    parameter int CB_CNT_W    = CB_CNT_W_DEF,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                i_core_clk,
    input  logic                i_rx_rst,
    input  logic                i_rdm_slot_start,
    input  logic                i_cfg_we,
    input  logic [USER_W-1:0]   i_cfg_user,
    input  logic [CB_CNT_W-1:0] i_cfg_cb_num,
    input  logic [E01_W-1:0]    i_cfg_e01,
    input  logic [NCB_W-1:0]    i_cfg_ncb,
    output logic                o_Combine_process_request,
    output logic [USER_W-1:0]   o_Combine_user_index,
    output logic [E01_W-1:0]    o_Current_Combine_E01_Size,
    output logic [NCB_W-1:0]    o_Current_Combine_Ncb_Size,
    input  logic                i_current_cb_combine_comp,
    output logic [CB_CNT_W-1:0] o_cb_index,
    output logic                o_busy,
    output logic                o_slot_comp,
    output logic [ERR_W-1:0]    o_err_flags
);

    localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [USER_W-1:0] LAST_USER = USER_W'(NUM_USERS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    sched_state_e        state_reg, state_next;
    logic [USER_W-1:0]   user_reg, user_next;
    logic [CB_CNT_W-1:0] cb_reg, cb_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic                req_reg, req_next;
    logic [USER_W-1:0]   out_user_reg, out_user_next;
    logic [E01_W-1:0]    out_e01_reg, out_e01_next;
    logic [NCB_W-1:0]    out_ncb_reg, out_ncb_next;
    logic [CB_CNT_W-1:0] out_cb_reg, out_cb_next;
    logic                slot_comp_reg, slot_comp_next;
    logic [ERR_W-1:0]    err_reg, err_next;

    logic                busy;
    logic [CB_CNT_W-1:0] tbl_cb_num;
    logic [E01_W-1:0]    tbl_e01;
    logic [NCB_W-1:0]    tbl_ncb;
    logic [CB_CNT_W:0]   cb_inc;

    // Busy is simply "not idle": it rises the cycle after start and falls with o_slot_comp.
    assign busy   = (state_reg != ST_IDLE);
    assign cb_inc = {1'b0, cb_reg} + (CB_CNT_W + 1)'(1);

    harq_user_cfg_table #(
        .NUM_USERS (NUM_USERS),
        .CB_CNT_W  (CB_CNT_W)
    ) u_cfg_table (
        .i_core_clk (i_core_clk),
        .i_rx_rst   (i_rx_rst),
        .busy       (busy),
        .wr_en      (i_cfg_we),
        .wr_user    (i_cfg_user),
        .wr_cb_num  (i_cfg_cb_num),
        .wr_e01     (i_cfg_e01),
        .wr_ncb     (i_cfg_ncb),
        .rd_user    (user_reg),
        .rd_cb_num  (tbl_cb_num),
        .rd_e01     (tbl_e01),
        .rd_ncb     (tbl_ncb)
    );

    always_comb begin
        state_next     = state_reg;
        user_next      = user_reg;
        cb_next        = cb_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        req_next       = 1'b0;
        out_user_next  = out_user_reg;
        out_e01_next   = out_e01_reg;
        out_ncb_next   = out_ncb_reg;
        out_cb_next    = out_cb_reg;
        slot_comp_next = 1'b0;
        err_next       = err_reg;

        if (i_cfg_we && busy) begin
            err_next[ERR_CFG_BUSY] = 1'b1;
        end
        if (i_rdm_slot_start && busy) begin
            err_next[ERR_SLOT_OVERRUN] = 1'b1;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (i_rdm_slot_start) begin
                    state_next = ST_SCAN;
                    user_next  = '0;
                    cb_next    = '0;
                end
            end
            ST_SCAN: begin
                if (tbl_cb_num != '0) begin
                    state_next = ST_ISSUE;
                end else if (user_reg == LAST_USER) begin
                    state_next = ST_DONE;
                end else begin
                    user_next = user_reg + USER_W'(1);
                end
            end
            ST_ISSUE: begin
                out_user_next = user_reg;
                out_e01_next  = tbl_e01;
                out_ncb_next  = tbl_ncb;
                out_cb_next   = cb_reg;
                req_next      = 1'b1;
                tmo_cnt_next  = '0;
                state_next    = ST_WAIT_COMP;
            end
            ST_WAIT_COMP: begin
                if (i_current_cb_combine_comp) begin
                    state_next = ST_NEXT_CB;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    err_next[ERR_TIMEOUT] = 1'b1;
                    state_next            = ST_DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            ST_NEXT_CB: begin
                if (cb_inc < {1'b0, tbl_cb_num}) begin
                    cb_next    = cb_inc[CB_CNT_W-1:0];
                    state_next = ST_ISSUE;
                end else begin
                    cb_next = '0;
                    if (user_reg == LAST_USER) begin
                        state_next = ST_DONE;
                    end else begin
                        user_next  = user_reg + USER_W'(1);
                        state_next = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                slot_comp_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_reg     <= ST_IDLE;
            user_reg      <= '0;
            cb_reg        <= '0;
            tmo_cnt_reg   <= '0;
            req_reg       <= 1'b0;
            out_user_reg  <= '0;
            out_e01_reg   <= '0;
            out_ncb_reg   <= '0;
            out_cb_reg    <= '0;
            slot_comp_reg <= 1'b0;
            err_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            user_reg      <= user_next;
            cb_reg        <= cb_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            req_reg       <= req_next;
            out_user_reg  <= out_user_next;
            out_e01_reg   <= out_e01_next;
            out_ncb_reg   <= out_ncb_next;
            out_cb_reg    <= out_cb_next;
            slot_comp_reg <= slot_comp_next;
            err_reg       <= err_next;
        end
    end

    assign o_Combine_process_request  = req_reg;
    assign o_Combine_user_index       = out_user_reg;
    assign o_Current_Combine_E01_Size = out_e01_reg;
    assign o_Current_Combine_Ncb_Size = out_ncb_reg;
    assign o_cb_index                 = out_cb_reg;
    assign o_busy                     = busy;
    assign o_slot_comp                = slot_comp_reg;
    assign o_err_flags                = err_reg;

endmodule
